// File: rtl/spi_slave_gen_if.sv
// Pin-side and wrapper-side signals of the SPI slave, bundled for port connection.
// The slave modport is the device view; master is the host/wrapper view.
interface spi_slave_gen_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              ss_n;
  logic              mosi;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              rx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              tx_done;
  logic              frame_err;
  logic              addr_pending;
  logic              busy;

  modport slave (
    input  ss_n, mosi, tx_valid, tx_data,
    output miso, rx_valid, rx_data, tx_done, frame_err, addr_pending, busy
  );

  modport master (
    output ss_n, mosi, tx_valid, tx_data,
    input  miso, rx_valid, rx_data, tx_done, frame_err, addr_pending, busy
  );
endinterface

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave: deserialises {cmd, payload} frames from MOSI and serialises
// read-back words on MISO, with read-wait timeout and SS_n abort detection.
module spi_slave_gen #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_gen_if.slave bus
);
  localparam int unsigned FrameW = DATA_W + 2;
  localparam int unsigned CntW   = $clog2(FrameW + 1);
  localparam int unsigned WaitW  = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StChkCmd, StRxWr, StRxRaddr, StRxRdata, StWaitTx, StTx
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [FrameW-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic                miso_q, miso_d;
  logic                rx_valid_q, rx_valid_d;
  logic [FrameW-1:0]   rx_data_q, rx_data_d;
  logic                tx_done_q, tx_done_d;
  logic                frame_err_q, frame_err_d;
  logic                pend_q, pend_d;

  logic [FrameW-1:0]   rx_next;
  logic                tx_bit;
  logic [DATA_W-1:0]   tx_shifted;

  always_comb begin
    if (LSB_FIRST) begin
      rx_next    = {bus.mosi, rx_sr_q[FrameW-1:1]};
      tx_bit     = tx_sr_q[0];
      tx_shifted = {1'b0, tx_sr_q[DATA_W-1:1]};
    end else begin
      rx_next    = {rx_sr_q[FrameW-2:0], bus.mosi};
      tx_bit     = tx_sr_q[DATA_W-1];
      tx_shifted = {tx_sr_q[DATA_W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    tx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    pend_d      = pend_q;

    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (!bus.ss_n) state_d = StChkCmd;
      end
      StChkCmd: begin
        cnt_d = '0;
        if (bus.ss_n)       state_d = StIdle;
        else if (!bus.mosi) state_d = StRxWr;
        else if (pend_q)    state_d = StRxRdata;
        else                state_d = StRxRaddr;
      end
      StRxWr, StRxRaddr, StRxRdata: begin
        // SS_n release wins over a last-bit completion on the same edge.
        if (bus.ss_n) begin
          state_d     = StIdle;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          rx_sr_d = rx_next;
          if (cnt_q == CntW'(FrameW - 1)) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            wait_d     = '0;
            if (state_q == StRxRdata) begin
              state_d = StWaitTx;
            end else begin
              state_d = StIdle;
              if (state_q == StRxRaddr) pend_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StWaitTx: begin
        if (bus.ss_n) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else if (bus.tx_valid) begin
          tx_sr_d = bus.tx_data;
          cnt_d   = '0;
          state_d = StTx;
        end else if (wait_q == WaitW'(TX_TIMEOUT - 1)) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StTx: begin
        if (bus.ss_n) begin
          state_d     = StIdle;
          cnt_d       = '0;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else begin
          miso_d  = tx_bit;
          tx_sr_d = tx_shifted;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            state_d   = StIdle;
            cnt_d     = '0;
            tx_done_d = 1'b1;
            pend_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wait_q      <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      tx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      tx_done_q   <= tx_done_d;
      frame_err_q <= frame_err_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.miso         = miso_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.tx_done      = tx_done_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.addr_pending = pend_q;
  assign bus.busy         = (state_q != StIdle);
endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: an MSB-first 8-bit instance (short timeout) driven from a
// frame table plus corner sequences, and an LSB-first 16-bit instance.
module tb_spi_slave_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  spi_slave_gen_if #(.DATA_W(8))  bus0 ();
  spi_slave_gen_if #(.DATA_W(16)) bus1 ();

  spi_slave_gen #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(5)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  spi_slave_gen #(.DATA_W(16), .LSB_FIRST(1'b1), .TX_TIMEOUT(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic       hdr;
    logic [9:0] bits;
    logic       use_tx;
    logic [7:0] tx;
    logic [9:0] exp_rx;
    logic       exp_pend;
    logic [7:0] exp_miso;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One IDLE->CHK_CMD cycle, header bit, then the frame MSB first; ends just after the last-bit edge.
  task automatic rx_frame0(input logic hdr, input logic [9:0] w);
    bus0.ss_n = 1'b0;
    bus0.mosi = 1'b0;
    step();
    bus0.mosi = hdr;
    step();
    for (int i = 9; i >= 0; i--) begin
      bus0.mosi = w[i];
      step();
    end
    bus0.mosi = 1'b0;
  endtask

  task automatic rx_frame1(input logic hdr, input logic [17:0] w);
    bus1.ss_n = 1'b0;
    bus1.mosi = 1'b0;
    step();
    bus1.mosi = hdr;
    step();
    for (int i = 0; i < 18; i++) begin
      bus1.mosi = w[i];
      step();
    end
    bus1.mosi = 1'b0;
  endtask

  initial begin
    logic [7:0]  got8;
    logic [15:0] got16;
    int          bad;
    logic [9:0]  last_rx;

    vecs[0] = '{hdr: 1'b0, bits: 10'h0A5, use_tx: 1'b0, tx: 8'h00, exp_rx: 10'h0A5,
                exp_pend: 1'b0, exp_miso: 8'h00};
    vecs[1] = '{hdr: 1'b1, bits: 10'h210, use_tx: 1'b0, tx: 8'h00, exp_rx: 10'h210,
                exp_pend: 1'b1, exp_miso: 8'h00};
    vecs[2] = '{hdr: 1'b1, bits: 10'h300, use_tx: 1'b1, tx: 8'hC3, exp_rx: 10'h300,
                exp_pend: 1'b1, exp_miso: 8'hC3};
    vecs[3] = '{hdr: 1'b0, bits: 10'h000, use_tx: 1'b0, tx: 8'h00, exp_rx: 10'h000,
                exp_pend: 1'b0, exp_miso: 8'h00};
    vecs[4] = '{hdr: 1'b1, bits: 10'h155, use_tx: 1'b0, tx: 8'h00, exp_rx: 10'h155,
                exp_pend: 1'b1, exp_miso: 8'h00};
    vecs[5] = '{hdr: 1'b1, bits: 10'h2AA, use_tx: 1'b1, tx: 8'h5A, exp_rx: 10'h2AA,
                exp_pend: 1'b1, exp_miso: 8'h5A};
    vecs[6] = '{hdr: 1'b0, bits: 10'h3FF, use_tx: 1'b0, tx: 8'h00, exp_rx: 10'h3FF,
                exp_pend: 1'b0, exp_miso: 8'h00};

    rst_n = 1'b0;
    bus0.ss_n = 1'b1; bus0.mosi = 1'b0; bus0.tx_valid = 1'b0; bus0.tx_data = '0;
    bus1.ss_n = 1'b1; bus1.mosi = 1'b0; bus1.tx_valid = 1'b0; bus1.tx_data = '0;
    step();
    step();
    chk("reset_miso", bus0.miso, 0);
    chk("reset_rx_valid", bus0.rx_valid, 0);
    chk("reset_rx_data", bus0.rx_data, 0);
    chk("reset_tx_done", bus0.tx_done, 0);
    chk("reset_frame_err", bus0.frame_err, 0);
    chk("reset_addr_pending", bus0.addr_pending, 0);
    chk("reset_busy", bus0.busy, 0);
    rst_n = 1'b1;
    step();

    // Frame table on the MSB-first instance.
    for (int v = 0; v < NV; v++) begin
      rx_frame0(vecs[v].hdr, vecs[v].bits);
      chk("vec_rx_valid", bus0.rx_valid, 1);
      chk("vec_rx_data", bus0.rx_data, 32'(vecs[v].exp_rx));
      chk("vec_addr_pending", bus0.addr_pending, 32'(vecs[v].exp_pend));
      if (vecs[v].use_tx) begin
        bus0.tx_valid = 1'b1;
        bus0.tx_data  = vecs[v].tx;
        step();
        bus0.tx_valid = 1'b0;
        chk("vec_rx_valid_pulse", bus0.rx_valid, 0);
        got8 = '0;
        bad  = 0;
        for (int k = 0; k < 8; k++) begin
          step();
          got8[7-k] = bus0.miso;
          if (k < 7 && bus0.tx_done) bad++;
        end
        chk("vec_tx_done_early", 32'(bad), 0);
        chk("vec_tx_done", bus0.tx_done, 1);
        chk("vec_miso_bits", 32'(got8), 32'(vecs[v].exp_miso));
        bus0.ss_n = 1'b1;
        step();
        chk("vec_miso_idle", bus0.miso, 0);
        chk("vec_tx_done_pulse", bus0.tx_done, 0);
        chk("vec_pending_cleared", bus0.addr_pending, 0);
      end else begin
        bus0.ss_n = 1'b1;
        step();
        chk("vec_rx_valid_pulse", bus0.rx_valid, 0);
        chk("vec_busy_idle", bus0.busy, 0);
      end
    end
    last_rx = 10'h3FF;

    // SS_n released after 5 write bits: abort, rx_data untouched.
    bus0.ss_n = 1'b0;
    step();
    bus0.mosi = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      bus0.mosi = 1'b0;
      step();
    end
    bus0.ss_n = 1'b1;
    step();
    chk("abort_frame_err", bus0.frame_err, 1);
    chk("abort_rx_valid", bus0.rx_valid, 0);
    chk("abort_rx_data", bus0.rx_data, 32'(last_rx));
    chk("abort_busy", bus0.busy, 0);
    step();
    chk("abort_frame_err_pulse", bus0.frame_err, 0);

    // Read-data frame with no tx_valid: frame_err exactly 5 cycles after WAIT_TX entry.
    rx_frame0(1'b1, 10'h220);
    chk("to_raddr_pending", bus0.addr_pending, 1);
    rx_frame0(1'b1, 10'h300);
    bad = 0;
    for (int c = 1; c < 5; c++) begin
      step();
      if (bus0.frame_err) bad++;
    end
    chk("to_early_err", 32'(bad), 0);
    step();
    chk("to_frame_err", bus0.frame_err, 1);
    chk("to_pending_kept", bus0.addr_pending, 1);
    chk("to_busy", bus0.busy, 0);
    bus0.ss_n = 1'b1;
    step();
    chk("to_frame_err_pulse", bus0.frame_err, 0);

    // SS_n released mid-TX: abort, MISO low, pending kept.
    rx_frame0(1'b1, 10'h3C0);
    bus0.tx_valid = 1'b1;
    bus0.tx_data  = 8'hFF;
    step();
    bus0.tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("txab_miso_mid", bus0.miso, 1);
    bus0.ss_n = 1'b1;
    step();
    chk("txab_frame_err", bus0.frame_err, 1);
    chk("txab_miso", bus0.miso, 0);
    chk("txab_tx_done", bus0.tx_done, 0);
    chk("txab_pending", bus0.addr_pending, 1);
    step();

    // LSB-first 16-bit instance: first serial bit lands in rx_data[0].
    rx_frame1(1'b0, 18'h31234);
    chk("lsb_wr_valid", bus1.rx_valid, 1);
    chk("lsb_wr_data", bus1.rx_data, 32'h31234);
    rx_frame1(1'b1, 18'h200F0);
    chk("lsb_raddr_data", bus1.rx_data, 32'h200F0);
    chk("lsb_raddr_pending", bus1.addr_pending, 1);
    rx_frame1(1'b1, 18'h30001);
    chk("lsb_rdata_data", bus1.rx_data, 32'h30001);
    bus1.tx_valid = 1'b1;
    bus1.tx_data  = 16'h8001;
    step();
    bus1.tx_valid = 1'b0;
    got16 = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      got16[k] = bus1.miso;
      if (k == 0) chk("lsb_miso_first", bus1.miso, 1);
    end
    chk("lsb_miso_last", bus1.miso, 1);
    chk("lsb_tx_done", bus1.tx_done, 1);
    chk("lsb_miso_word", 32'(got16), 32'h8001);
    bus1.ss_n = 1'b1;
    step();
    chk("lsb_miso_idle", bus1.miso, 0);
    chk("lsb_pending_cleared", bus1.addr_pending, 0);

    // Reset after 3 TX bits, then a fresh write frame.
    rx_frame0(1'b1, 10'h3AB);
    bus0.tx_valid = 1'b1;
    bus0.tx_data  = 8'hE7;
    step();
    bus0.tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst_n     = 1'b0;
    bus0.ss_n = 1'b1;
    step();
    rst_n = 1'b1;
    chk("rst_miso", bus0.miso, 0);
    chk("rst_pending", bus0.addr_pending, 0);
    chk("rst_rx_data", bus0.rx_data, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_tx_done", bus0.tx_done, 0);
    chk("rst_frame_err", bus0.frame_err, 0);
    rx_frame0(1'b0, 10'h1C3);
    chk("rst_wr_valid", bus0.rx_valid, 1);
    chk("rst_wr_data", bus0.rx_data, 32'h1C3);
    bus0.ss_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
